// File: rtl/axi_shim_arbiter.sv
// axi_shim_arbiter
//   Shares one AXI shim request/response interface between NumReq requesters
//   (e.g. icache, dcache, PTW). Read and write request channels are arbitrated
//   independently with round-robin fairness. The winner's index is packed into
//   the upper bits of the shim ID so responses can be routed back. Each
//   requester has an outstanding-transaction counter per channel that blocks
//   new grants once MaxOutstanding transactions are in flight.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   rd_req_i / rd_gnt_o           per-requester read request / grant
//   rd_addr_i .. rd_lock_i        per-requester read request fields
//   rd_valid_o / rd_rdy_i         per-requester read beat valid / ready
//   rd_data_o .. rd_exokay_o      shared read beat payload (index bits stripped)
//   wr_req_i / wr_gnt_o           per-requester write request / grant
//   wr_addr_i .. wr_atop_i        per-requester write request fields (full lines)
//   wr_valid_o / wr_rdy_i         per-requester B valid / ready
//   wr_id_o, wr_exokay_o          shared B payload
//   shim_rd_*, shim_wr_*          downstream shim interface, IdWidth-wide IDs
//   rd_route_err_o/wr_route_err_o pulse when a response carries index >= NumReq
module axi_shim_arbiter #(
    parameter int NumReq         = 3,
    parameter int NumWords       = 4,
    parameter int ReqIdWidth     = 2,
    parameter int IdWidth        = 4,
    parameter int MaxOutstanding = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    // read requesters
    input  logic [NumReq-1:0]                           rd_req_i,
    output logic [NumReq-1:0]                           rd_gnt_o,
    input  logic [NumReq-1:0][63:0]                     rd_addr_i,
    input  logic [NumReq-1:0][$clog2(NumWords)-1:0]     rd_blen_i,
    input  logic [NumReq-1:0][1:0]                      rd_size_i,
    input  logic [NumReq-1:0][ReqIdWidth-1:0]           rd_id_i,
    input  logic [NumReq-1:0]                           rd_lock_i,
    output logic [NumReq-1:0]                           rd_valid_o,
    input  logic [NumReq-1:0]                           rd_rdy_i,
    output logic [63:0]                                 rd_data_o,
    output logic                                        rd_last_o,
    output logic [ReqIdWidth-1:0]                       rd_id_o,
    output logic                                        rd_exokay_o,
    // write requesters
    input  logic [NumReq-1:0]                           wr_req_i,
    output logic [NumReq-1:0]                           wr_gnt_o,
    input  logic [NumReq-1:0][63:0]                     wr_addr_i,
    input  logic [NumReq-1:0][NumWords*64-1:0]          wr_data_i,
    input  logic [NumReq-1:0][NumWords*8-1:0]           wr_be_i,
    input  logic [NumReq-1:0][$clog2(NumWords)-1:0]     wr_blen_i,
    input  logic [NumReq-1:0][1:0]                      wr_size_i,
    input  logic [NumReq-1:0][ReqIdWidth-1:0]           wr_id_i,
    input  logic [NumReq-1:0]                           wr_lock_i,
    input  logic [NumReq-1:0][5:0]                      wr_atop_i,
    output logic [NumReq-1:0]                           wr_valid_o,
    input  logic [NumReq-1:0]                           wr_rdy_i,
    output logic [ReqIdWidth-1:0]                       wr_id_o,
    output logic                                        wr_exokay_o,
    // shim read side
    output logic                                        shim_rd_req_o,
    input  logic                                        shim_rd_gnt_i,
    output logic [63:0]                                 shim_rd_addr_o,
    output logic [$clog2(NumWords)-1:0]                 shim_rd_blen_o,
    output logic [1:0]                                  shim_rd_size_o,
    output logic [IdWidth-1:0]                          shim_rd_id_o,
    output logic                                        shim_rd_lock_o,
    input  logic                                        shim_rd_valid_i,
    output logic                                        shim_rd_rdy_o,
    input  logic [63:0]                                 shim_rd_data_i,
    input  logic                                        shim_rd_last_i,
    input  logic [IdWidth-1:0]                          shim_rd_id_i,
    input  logic                                        shim_rd_exokay_i,
    // shim write side
    output logic                                        shim_wr_req_o,
    input  logic                                        shim_wr_gnt_i,
    output logic [63:0]                                 shim_wr_addr_o,
    output logic [NumWords*64-1:0]                      shim_wr_data_o,
    output logic [NumWords*8-1:0]                       shim_wr_be_o,
    output logic [$clog2(NumWords)-1:0]                 shim_wr_blen_o,
    output logic [1:0]                                  shim_wr_size_o,
    output logic [IdWidth-1:0]                          shim_wr_id_o,
    output logic                                        shim_wr_lock_o,
    output logic [5:0]                                  shim_wr_atop_o,
    input  logic                                        shim_wr_valid_i,
    output logic                                        shim_wr_rdy_o,
    input  logic [IdWidth-1:0]                          shim_wr_id_i,
    input  logic                                        shim_wr_exokay_i,
    // routing errors
    output logic                                        rd_route_err_o,
    output logic                                        wr_route_err_o
);

    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = $clog2(MaxOutstanding + 1);

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_HOLD = 1'b1;
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_HOLD = 1'b1;

    // First eligible index at or after ptr, wrapping around.
    function automatic logic [IdxW-1:0] rr_pick(input logic [NumReq-1:0] elig,
                                                input logic [IdxW-1:0]   ptr);
        logic [IdxW-1:0]   pick;
        logic [NumReq-1:0] sh;
        logic              found;
        int                k;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            k = int'(ptr) + i;
            if (k >= NumReq) k = k - NumReq;
            sh = elig >> k;
            if (!found && sh[0]) begin
                pick  = k[IdxW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [IdxW-1:0] next_ptr(input logic [IdxW-1:0] sel);
        return (sel == IdxW'(NumReq - 1)) ? '0 : sel + 1'b1;
    endfunction

    // Shim ID = zero-extended {requester index, requester ID}.
    function automatic logic [IdWidth-1:0] make_id(input logic [IdxW-1:0]       idx,
                                                   input logic [ReqIdWidth-1:0] rid);
        logic [IdWidth-1:0] id;
        id                      = '0;
        id[ReqIdWidth +: IdxW]  = idx;
        id[ReqIdWidth-1:0]      = rid;
        return id;
    endfunction

    // ------------------------------------------------------------------
    // Read channel arbitration
    // ------------------------------------------------------------------
    logic [0:0]        rd_state_q;
    logic [IdxW-1:0]   rd_ptr_q, rd_sel_q;
    logic [CntW-1:0]   rd_cnt_q [NumReq];
    logic [NumReq-1:0] rd_elig, rd_inc, rd_dec;
    logic [IdxW-1:0]   rd_win, rd_sel;
    logic              rd_req_any, rd_fire;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            rd_elig[i] = rd_req_i[i] && (rd_cnt_q[i] < CntW'(MaxOutstanding));
        end
    end

    assign rd_win     = rr_pick(rd_elig, rd_ptr_q);
    // In HOLD the selection is frozen so the request fields stay stable.
    assign rd_sel     = (rd_state_q == R_HOLD) ? rd_sel_q : rd_win;
    assign rd_req_any = (rd_state_q == R_HOLD) || (|rd_elig);
    assign rd_fire    = rd_req_any && shim_rd_gnt_i && !rst_i;

    assign shim_rd_req_o  = rd_req_any && !rst_i;
    assign rd_gnt_o       = rd_fire ? (NumReq'(1) << rd_sel) : '0;
    assign shim_rd_addr_o = rd_addr_i[rd_sel];
    assign shim_rd_blen_o = rd_blen_i[rd_sel];
    assign shim_rd_size_o = rd_size_i[rd_sel];
    assign shim_rd_lock_o = rd_lock_i[rd_sel];
    assign shim_rd_id_o   = make_id(rd_sel, rd_id_i[rd_sel]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state_q <= R_IDLE;
            rd_sel_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (|rd_elig) begin
                        if (shim_rd_gnt_i) begin
                            rd_ptr_q <= next_ptr(rd_win);
                        end else begin
                            rd_sel_q   <= rd_win;
                            rd_state_q <= R_HOLD;
                        end
                    end
                end
                R_HOLD: begin
                    if (shim_rd_gnt_i) begin
                        rd_ptr_q   <= next_ptr(rd_sel_q);
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write channel arbitration (selection held for the whole burst)
    // ------------------------------------------------------------------
    logic [0:0]        wr_state_q;
    logic [IdxW-1:0]   wr_ptr_q, wr_sel_q;
    logic [CntW-1:0]   wr_cnt_q [NumReq];
    logic [NumReq-1:0] wr_elig, wr_inc, wr_dec;
    logic [IdxW-1:0]   wr_win, wr_sel;
    logic              wr_req_any, wr_fire;

    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            wr_elig[i] = wr_req_i[i] && (wr_cnt_q[i] < CntW'(MaxOutstanding));
        end
    end

    assign wr_win     = rr_pick(wr_elig, wr_ptr_q);
    assign wr_sel     = (wr_state_q == W_HOLD) ? wr_sel_q : wr_win;
    assign wr_req_any = (wr_state_q == W_HOLD) || (|wr_elig);
    assign wr_fire    = wr_req_any && shim_wr_gnt_i && !rst_i;

    assign shim_wr_req_o  = wr_req_any && !rst_i;
    assign wr_gnt_o       = wr_fire ? (NumReq'(1) << wr_sel) : '0;
    assign shim_wr_addr_o = wr_addr_i[wr_sel];
    assign shim_wr_data_o = wr_data_i[wr_sel];
    assign shim_wr_be_o   = wr_be_i[wr_sel];
    assign shim_wr_blen_o = wr_blen_i[wr_sel];
    assign shim_wr_size_o = wr_size_i[wr_sel];
    assign shim_wr_lock_o = wr_lock_i[wr_sel];
    assign shim_wr_atop_o = wr_atop_i[wr_sel];
    assign shim_wr_id_o   = make_id(wr_sel, wr_id_i[wr_sel]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state_q <= W_IDLE;
            wr_sel_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (|wr_elig) begin
                        if (shim_wr_gnt_i) begin
                            wr_ptr_q <= next_ptr(wr_win);
                        end else begin
                            wr_sel_q   <= wr_win;
                            wr_state_q <= W_HOLD;
                        end
                    end
                end
                W_HOLD: begin
                    if (shim_wr_gnt_i) begin
                        wr_ptr_q   <= next_ptr(wr_sel_q);
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response routing by the index field of the returned ID
    // ------------------------------------------------------------------
    logic [IdxW-1:0] rd_rsp_idx, wr_rsp_idx;
    logic            rd_rsp_ok, wr_rsp_ok;

    assign rd_rsp_idx = shim_rd_id_i[ReqIdWidth +: IdxW];
    assign wr_rsp_idx = shim_wr_id_i[ReqIdWidth +: IdxW];
    assign rd_rsp_ok  = int'(rd_rsp_idx) < NumReq;
    assign wr_rsp_ok  = int'(wr_rsp_idx) < NumReq;

    // Unroutable beats are sunk so the shim never stalls on them.
    assign shim_rd_rdy_o  = rd_rsp_ok ? rd_rdy_i[rd_rsp_idx] : 1'b1;
    assign shim_wr_rdy_o  = wr_rsp_ok ? wr_rdy_i[wr_rsp_idx] : 1'b1;
    assign rd_valid_o     = (shim_rd_valid_i && rd_rsp_ok && !rst_i) ? (NumReq'(1) << rd_rsp_idx) : '0;
    assign wr_valid_o     = (shim_wr_valid_i && wr_rsp_ok && !rst_i) ? (NumReq'(1) << wr_rsp_idx) : '0;
    assign rd_route_err_o = shim_rd_valid_i && !rd_rsp_ok && !rst_i;
    assign wr_route_err_o = shim_wr_valid_i && !wr_rsp_ok && !rst_i;

    assign rd_data_o   = shim_rd_data_i;
    assign rd_last_o   = shim_rd_last_i;
    assign rd_id_o     = shim_rd_id_i[ReqIdWidth-1:0];
    assign rd_exokay_o = shim_rd_exokay_i;
    assign wr_id_o     = shim_wr_id_i[ReqIdWidth-1:0];
    assign wr_exokay_o = shim_wr_exokay_i;

    // ------------------------------------------------------------------
    // Outstanding-transaction counters
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NumReq; g++) begin : g_cnt
        assign rd_inc[g] = rd_gnt_o[g];
        assign rd_dec[g] = rd_valid_o[g] && shim_rd_rdy_o && shim_rd_last_i;
        assign wr_inc[g] = wr_gnt_o[g];
        assign wr_dec[g] = wr_valid_o[g] && shim_wr_rdy_o;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rd_cnt_q[g] <= '0;
            end else if (rd_inc[g] && !rd_dec[g]) begin
                if (rd_cnt_q[g] != CntW'(MaxOutstanding)) rd_cnt_q[g] <= rd_cnt_q[g] + 1'b1;
            end else if (rd_dec[g] && !rd_inc[g]) begin
                if (rd_cnt_q[g] != '0) rd_cnt_q[g] <= rd_cnt_q[g] - 1'b1;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wr_cnt_q[g] <= '0;
            end else if (wr_inc[g] && !wr_dec[g]) begin
                if (wr_cnt_q[g] != CntW'(MaxOutstanding)) wr_cnt_q[g] <= wr_cnt_q[g] + 1'b1;
            end else if (wr_dec[g] && !wr_inc[g]) begin
                if (wr_cnt_q[g] != '0) wr_cnt_q[g] <= wr_cnt_q[g] - 1'b1;
            end
        end

        // A completion for a requester with nothing in flight means the
        // shim returned a response that was never issued.
        a_rd_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
            !(rd_dec[g] && !rd_inc[g] && rd_cnt_q[g] == '0));
        a_wr_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
            !(wr_dec[g] && !wr_inc[g] && wr_cnt_q[g] == '0));
    end

endmodule
